// File: rtl/mci_sram_rr_arb_if.sv
// Requester/SRAM bus for the round-robin SRAM arbiter.
// The arbiter takes the slave view; requesters and the SRAM model take the master view.
interface mci_sram_rr_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      sram_cs;
  logic                      sram_we;
  logic [ADDR_W-1:0]         sram_addr;
  logic [DATA_W-1:0]         sram_wdata;
  logic [DATA_W-1:0]         sram_rdata;
  logic [OW-1:0]             lock_owner;
  logic                      lock_active;
  logic                      lock_tmo_err;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, sram_cs, sram_we, sram_addr,
           sram_wdata, lock_owner, lock_active, lock_tmo_err
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, sram_cs, sram_we, sram_addr,
           sram_wdata, lock_owner, lock_active, lock_tmo_err
  );
endinterface

// File: rtl/mci_sram_rr_arb.sv
// Round-robin arbiter giving NUM_REQ requesters access to one single-port SRAM.
// A requester may hold the SRAM with req_lock; an idle lock is broken after LOCK_TMO cycles.
// Responses return in order, RD_LAT+1 cycles after the grant.
module mci_sram_rr_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_TMO = 16
) (
  input  logic             clk,
  input  logic             mci_rst,
  mci_sram_rr_arb_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_TMO + 1);

  typedef logic [PW-1:0] id_t;
  typedef enum logic {LK_IDLE = 1'b0, LK_HELD = 1'b1} lk_state_e;

  lk_state_e r_lk_state;
  lk_state_e w_lk_next;
  id_t       r_rr_ptr;
  id_t       r_lock_owner;
  logic [CW-1:0] r_idle_cnt;
  logic      r_lock_tmo_err;

  logic              r_sram_cs;
  logic              r_sram_we;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;

  logic [RD_LAT-1:0]         r_pv;
  logic [RD_LAT-1:0]         r_pwe;
  logic [RD_LAT-1:0][PW-1:0] r_pid;
  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic                      r_rsp_we;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_hs;
  id_t                w_hs_id;
  id_t                w_scan_id;
  logic               w_found;
  logic               w_lock_sel;
  logic               w_tmo;

  function automatic id_t inc_id(input id_t x);
    return (32'(x) == NUM_REQ - 1) ? '0 : id_t'(32'(x) + 1);
  endfunction

  // Grant: owner-only while locked, otherwise first valid at or above rr_ptr (wrapping).
  always_comb begin
    w_grant   = '0;
    w_hs      = 1'b0;
    w_hs_id   = '0;
    w_scan_id = '0;
    w_found   = 1'b0;
    if (!mci_rst) begin
      if (r_lk_state == LK_HELD) begin
        if (bus.req_valid[r_lock_owner]) begin
          w_grant[r_lock_owner] = 1'b1;
          w_hs    = 1'b1;
          w_hs_id = r_lock_owner;
        end
      end else begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          w_scan_id = id_t'((32'(r_rr_ptr) + k) % NUM_REQ);
          if (!w_found && bus.req_valid[w_scan_id]) begin
            w_found            = 1'b1;
            w_grant[w_scan_id] = 1'b1;
            w_hs               = 1'b1;
            w_hs_id            = w_scan_id;
          end
        end
      end
    end
  end

  assign w_lock_sel = bus.req_lock[w_hs_id];

  // Lock FSM state register.
  always_ff @(posedge clk or posedge mci_rst) begin
    if (mci_rst) r_lk_state <= LK_IDLE;
    else         r_lk_state <= w_lk_next;
  end

  // Lock FSM next state; the timeout fires on the idle cycle that would bring the count to LOCK_TMO.
  always_comb begin
    w_lk_next = r_lk_state;
    w_tmo     = 1'b0;
    case (r_lk_state)
      LK_IDLE: begin
        if (w_hs && w_lock_sel) w_lk_next = LK_HELD;
      end
      LK_HELD: begin
        if (w_hs) begin
          if (!w_lock_sel) w_lk_next = LK_IDLE;
        end else if (r_idle_cnt == CW'(LOCK_TMO - 1)) begin
          w_tmo     = 1'b1;
          w_lk_next = LK_IDLE;
        end
      end
      default: w_lk_next = LK_IDLE;
    endcase
  end

  // Round-robin pointer, lock owner, idle counter and timeout pulse.
  always_ff @(posedge clk or posedge mci_rst) begin
    if (mci_rst) begin
      r_rr_ptr       <= '0;
      r_lock_owner   <= '0;
      r_idle_cnt     <= '0;
      r_lock_tmo_err <= 1'b0;
    end else begin
      r_lock_tmo_err <= w_tmo;
      if (w_hs)       r_rr_ptr <= inc_id(w_hs_id);
      else if (w_tmo) r_rr_ptr <= inc_id(r_lock_owner);
      if (w_hs && w_lock_sel) r_lock_owner <= w_hs_id;
      if (r_lk_state == LK_HELD && w_lk_next == LK_HELD && !w_hs)
        r_idle_cnt <= r_idle_cnt + CW'(1);
      else
        r_idle_cnt <= '0;
    end
  end

  // Registered SRAM request; address/data/we hold when no request is issued.
  always_ff @(posedge clk or posedge mci_rst) begin
    if (mci_rst) begin
      r_sram_cs    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      r_sram_cs <= w_hs;
      if (w_hs) begin
        r_sram_we    <= bus.req_we[w_hs_id];
        r_sram_addr  <= bus.req_addr[32'(w_hs_id)*ADDR_W +: ADDR_W];
        r_sram_wdata <= bus.req_wdata[32'(w_hs_id)*DATA_W +: DATA_W];
      end
    end
  end

  // Owner/we shift pipeline aligned with SRAM read latency, then the response register.
  always_ff @(posedge clk or posedge mci_rst) begin
    if (mci_rst) begin
      r_pv        <= '0;
      r_pwe       <= '0;
      r_pid       <= '0;
      r_rsp_valid <= '0;
      r_rsp_we    <= 1'b0;
    end else begin
      r_pv[0]  <= w_hs;
      r_pwe[0] <= bus.req_we[w_hs_id];
      r_pid[0] <= w_hs_id;
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        r_pv[s]  <= r_pv[s-1];
        r_pwe[s] <= r_pwe[s-1];
        r_pid[s] <= r_pid[s-1];
      end
      r_rsp_valid <= '0;
      if (r_pv[RD_LAT-1]) r_rsp_valid[r_pid[RD_LAT-1]] <= 1'b1;
      r_rsp_we <= r_pwe[RD_LAT-1];
    end
  end

  assign bus.req_ready    = w_grant;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = (|r_rsp_valid && !r_rsp_we) ? bus.sram_rdata : '0;
  assign bus.sram_cs      = r_sram_cs;
  assign bus.sram_we      = r_sram_we;
  assign bus.sram_addr    = r_sram_addr;
  assign bus.sram_wdata   = r_sram_wdata;
  assign bus.lock_owner   = r_lock_owner;
  assign bus.lock_active  = (r_lk_state == LK_HELD);
  assign bus.lock_tmo_err = r_lock_tmo_err;
endmodule

// File: tb/tb_mci_sram_rr_arb.sv
// Directed bench for mci_sram_rr_arb: stimulus pushes expected responses into a
// scoreboard queue, an independent monitor pops and compares on each rsp_valid.
module tb_mci_sram_rr_arb;
  localparam int NR  = 4;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int RL  = 2;
  localparam int TMO = 4;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic mci_rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0;
  int   rsp_cnt = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mci_sram_rr_arb_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mci_sram_rr_arb #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .LOCK_TMO(TMO)
  ) dut (
    .clk(clk),
    .mci_rst(mci_rst),
    .bus(bus)
  );

  // SRAM model: unwritten words read as 0xC0DE_0000 + address; two-cycle read latency.
  logic [31:0] wr_mem [int];
  logic [31:0] rd0 = '0;
  logic [31:0] rd1 = '0;
  always @(posedge clk) begin
    if (bus.sram_cs && bus.sram_we) wr_mem[int'(bus.sram_addr)] = bus.sram_wdata;
    if (bus.sram_cs && !bus.sram_we)
      rd0 <= wr_mem.exists(int'(bus.sram_addr)) ? wr_mem[int'(bus.sram_addr)]
                                                : 32'hC0DE_0000 + 32'(bus.sram_addr);
    else
      rd0 <= 32'hDEAD_BEEF;
    rd1 <= rd0;
  end
  assign bus.sram_rdata = rd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [3:0] oh);
    int r = -1;
    for (int i = 0; i < NR; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  // One cycle: drive flags, check the grant, and queue the expected response.
  task automatic step(input string nm, input logic [3:0] v, input logic [3:0] we,
                      input logic [3:0] lk, input logic [3:0] exp_rdy,
                      input logic [31:0] exp_data, input bit track = 1'b1);
    exp_t e;
    tick();
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_lock  = lk;
    #1;
    chk(nm, 32'(bus.req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0 && track) begin
      e.id   = oh2id(exp_rdy);
      e.data = exp_data;
      e.due  = cyc + RL + 1;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle_ready", 4'b0, 4'b0, 4'b0, 4'b0, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"},     32'(bus.req_ready),    32'h0);
    chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid),    32'h0);
    chk({nm, "_rsp_rdata"}, bus.rsp_rdata,         32'h0);
    chk({nm, "_sram_cs"},   32'(bus.sram_cs),      32'h0);
    chk({nm, "_sram_we"},   32'(bus.sram_we),      32'h0);
    chk({nm, "_sram_addr"}, 32'(bus.sram_addr),    32'h0);
    chk({nm, "_sram_wdata"}, bus.sram_wdata,       32'h0);
    chk({nm, "_lock_owner"}, 32'(bus.lock_owner),  32'h0);
    chk({nm, "_lock_active"}, 32'(bus.lock_active), 32'h0);
    chk({nm, "_tmo_err"},   32'(bus.lock_tmo_err), 32'h0);
  endtask

  // Handshake counter; reset drops whatever is in flight.
  always @(posedge clk) begin
    if (mci_rst) hs_cnt = rsp_cnt;
    else         hs_cnt += $countones(bus.req_valid & bus.req_ready);
  end

  // Monitor: grant shape every cycle, response comparison against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (!$onehot0(bus.req_ready)) begin
      errors++;
      $display("FAIL ready_onehot at cycle %0d: got %b", cyc, bus.req_ready);
    end
    if (!mci_rst) begin
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing at cycle %0d: requester %0d due cycle %0d", cyc, sbq[0].id, sbq[0].due);
        void'(sbq.pop_front());
      end
      if (bus.rsp_valid != '0) begin
        rsp_cnt += $countones(bus.rsp_valid);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected at cycle %0d: got rsp_valid %b, required none", cyc, bus.rsp_valid);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(4'b0001 << e.id));
          chk("rsp_rdata", bus.rsp_rdata, e.data);
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    mci_rst       = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < NR; i++) set_req(i, AW'(32'h20 + i), '0);

    // Reset state with all requesters asking.
    tick(); tick(); tick();
    #1;
    chk_reset_outputs("rst0");

    tick();
    mci_rst       = 1'b0;
    bus.req_valid = '0;

    // Four requesters reading continuously: strict rotation.
    for (int r = 0; r < 2; r++) begin
      step("rr_g0", 4'b1111, 4'b0, 4'b0, 4'b0001, 32'hC0DE_0020);
      step("rr_g1", 4'b1111, 4'b0, 4'b0, 4'b0010, 32'hC0DE_0021);
      step("rr_g2", 4'b1111, 4'b0, 4'b0, 4'b0100, 32'hC0DE_0022);
      step("rr_g3", 4'b1111, 4'b0, 4'b0, 4'b1000, 32'hC0DE_0023);
    end
    idle(4);

    // Write by requester 1, read-back by requester 2.
    set_req(1, 10'h010, 32'hA5A5_0001);
    set_req(2, 10'h010, 32'h0);
    step("wr1_ready", 4'b0010, 4'b0010, 4'b0, 4'b0010, 32'h0);
    step("rd2_ready", 4'b0100, 4'b0000, 4'b0, 4'b0100, 32'hA5A5_0001);
    chk("wr_sram_cs",    32'(bus.sram_cs),   32'h1);
    chk("wr_sram_we",    32'(bus.sram_we),   32'h1);
    chk("wr_sram_addr",  32'(bus.sram_addr), 32'h10);
    chk("wr_sram_wdata", bus.sram_wdata,     32'hA5A5_0001);
    idle(1);
    chk("rd_sram_cs",    32'(bus.sram_cs),   32'h1);
    chk("rd_sram_we",    32'(bus.sram_we),   32'h0);
    chk("rd_sram_wdata", bus.sram_wdata,     32'h0);
    idle(1);
    chk("idle_sram_cs",   32'(bus.sram_cs),   32'h0);
    chk("idle_sram_addr", 32'(bus.sram_addr), 32'h10);
    idle(2);
    set_req(1, 10'h021, '0);
    set_req(2, 10'h022, '0);

    // Requester 3 holds a lock across three handshakes while requester 0 waits.
    step("lk_g3a", 4'b1001, 4'b0, 4'b1000, 4'b1000, 32'hC0DE_0023);
    step("lk_g3b", 4'b1001, 4'b0, 4'b1000, 4'b1000, 32'hC0DE_0023);
    chk("lk_active", 32'(bus.lock_active), 32'h1);
    chk("lk_owner",  32'(bus.lock_owner),  32'h3);
    step("lk_g3c", 4'b1001, 4'b0, 4'b1000, 4'b1000, 32'hC0DE_0023);
    step("lk_g3u", 4'b1001, 4'b0, 4'b0000, 4'b1000, 32'hC0DE_0023);
    chk("lk_still_active", 32'(bus.lock_active), 32'h1);
    step("lk_g0", 4'b1001, 4'b0, 4'b0000, 4'b0001, 32'hC0DE_0020);
    chk("lk_released", 32'(bus.lock_active), 32'h0);
    idle(4);

    // Requester 2 locks then goes quiet: timeout after four idle cycles.
    step("tmo_g2", 4'b0100, 4'b0, 4'b0100, 4'b0100, 32'hC0DE_0022);
    for (int i = 0; i < TMO; i++) begin
      step("tmo_blocked", 4'b1011, 4'b0, 4'b0, 4'b0000, 32'h0);
      chk("tmo_held",    32'(bus.lock_active),  32'h1);
      chk("tmo_no_err",  32'(bus.lock_tmo_err), 32'h0);
    end
    step("tmo_g3", 4'b1011, 4'b0, 4'b0, 4'b1000, 32'hC0DE_0023);
    chk("tmo_err_pulse", 32'(bus.lock_tmo_err), 32'h1);
    chk("tmo_unlocked",  32'(bus.lock_active),  32'h0);
    idle(1);
    chk("tmo_err_end", 32'(bus.lock_tmo_err), 32'h0);
    idle(4);

    // Reset with two reads in flight: no responses, outputs zero, fresh pointer.
    step("fl_g0", 4'b0011, 4'b0, 4'b0, 4'b0001, 32'h0, 1'b0);
    step("fl_g1", 4'b0011, 4'b0, 4'b0, 4'b0010, 32'h0, 1'b0);
    tick();
    mci_rst = 1'b1;
    #1;
    chk_reset_outputs("rst1");
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk_reset_outputs("rst_hold");
    end
    tick();
    mci_rst       = 1'b0;
    bus.req_valid = '0;
    step("post_g0", 4'b1011, 4'b0, 4'b0, 4'b0001, 32'hC0DE_0020);
    step("post_g1", 4'b1011, 4'b0, 4'b0, 4'b0010, 32'hC0DE_0021);
    step("post_g3", 4'b1011, 4'b0, 4'b0, 4'b1000, 32'hC0DE_0023);
    idle(5);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    chk("hs_vs_rsp", 32'(hs_cnt), 32'(rsp_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
